// File: rtl/accel_job_sched.sv
// Accelerator job scheduler: streams len words from memory to the
// accelerator and writes the accelerator's result stream back to memory.
module accel_job_sched #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [ADDR_WIDTH-1:0] cfg_src_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic                  sts_err,
  output logic [LEN_WIDTH-1:0]  sts_wr_count,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_rsp_valid,
  output logic                  rd_rsp_ready,
  input  logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ABORT
  } state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  fwd_q;
  logic [3:0]            outstanding;
  logic                  tlast_q;

  logic run;
  logic abrt;
  logic req_hs;
  logic rsp_hs;
  logic fwd_hs;
  logic wr_hs;
  logic last_hs;
  logic fwd_done;
  logic tl_done;

  assign run  = (state == RUN);
  assign abrt = (state == ABORT);

  assign rd_req_valid = run && (issued_q < len_q) && (outstanding < MAX_OUT);
  assign rd_req_addr  = rd_addr_q;

  assign m_tvalid     = run && rd_rsp_valid;
  assign m_tdata      = run ? rd_rsp_data : '0;
  assign m_tlast      = m_tvalid && (fwd_q == len_q - LEN_ONE);
  assign rd_rsp_ready = (run && m_tready) || abrt;

  // Once the accelerator has signalled tlast, its stream is closed for the job.
  assign wr_valid = run && s_tvalid && !tlast_q;
  assign wr_data  = run ? s_tdata : '0;
  assign wr_addr  = wr_addr_q;
  assign s_tready = (run && wr_ready && !tlast_q) || abrt;

  assign req_hs  = rd_req_valid && rd_req_ready;
  assign rsp_hs  = rd_rsp_valid && rd_rsp_ready;
  assign fwd_hs  = run && rsp_hs;
  assign wr_hs   = wr_valid && wr_ready;
  assign last_hs = wr_hs && s_tlast;

  assign fwd_done = (fwd_q == len_q) || (fwd_hs && m_tlast);
  assign tl_done  = tlast_q || last_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      fwd_q        <= '0;
      outstanding  <= '0;
      tlast_q      <= 1'b0;
      sts_busy     <= 1'b0;
      sts_done     <= 1'b0;
      sts_err      <= 1'b0;
      sts_wr_count <= '0;
    end else begin
      if (req_hs && !rsp_hs) begin
        outstanding <= outstanding + 4'd1;
      end else if (!req_hs && rsp_hs && outstanding != 4'd0) begin
        outstanding <= outstanding - 4'd1;
      end
      if (req_hs) begin
        rd_addr_q <= rd_addr_q + ADDR_ONE;
        issued_q  <= issued_q + LEN_ONE;
      end
      if (fwd_hs) begin
        fwd_q <= fwd_q + LEN_ONE;
      end
      if (wr_hs) begin
        wr_addr_q <= wr_addr_q + ADDR_ONE;
        if (sts_wr_count != '1) begin
          sts_wr_count <= sts_wr_count + LEN_ONE;
        end
      end
      if (last_hs) begin
        tlast_q <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (cfg_start && cfg_len != '0) begin
            state        <= RUN;
            rd_addr_q    <= cfg_src_addr;
            wr_addr_q    <= cfg_dst_addr;
            len_q        <= cfg_len;
            issued_q     <= '0;
            fwd_q        <= '0;
            tlast_q      <= 1'b0;
            sts_busy     <= 1'b1;
            sts_done     <= 1'b0;
            sts_err      <= 1'b0;
            sts_wr_count <= '0;
          end else if (cfg_start) begin
            sts_err  <= 1'b1;
            sts_done <= 1'b0;
          end
        end
        RUN: begin
          if (fwd_done && tl_done) begin
            state    <= IDLE;
            sts_busy <= 1'b0;
            sts_done <= 1'b1;
          end else if (cfg_abort) begin
            state <= ABORT;
          end
        end
        ABORT: begin
          if (outstanding == 4'd0) begin
            state    <= IDLE;
            sts_busy <= 1'b0;
            sts_err  <= 1'b1;
            sts_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    rsp_hs |-> outstanding != 4'd0);
  a_max_out: assert property (@(posedge clk) disable iff (rst)
    outstanding <= MAX_OUT);

endmodule
